free_list: RTL

FREE_LIST -- requirements
Module: free_list

---
 rtl/free_list.sv | 128 ++++++++++++
 1 files changed

// File: rtl/free_list.sv
// Physical register free list for a register-renaming pipeline.
// A circular buffer of DEPTH physical register indices with a speculative
// allocation head, an architectural (retired) head used for mispredict
// recovery, and a tail where retire returns displaced registers.
//
// Ports:
//   clk            clock, all state updates on posedge
//   reset          asynchronous active-high reset
//   alloc_req      rename requests one free physical register
//   alloc_pr       physical register at the head (combinational read)
//   alloc_valid    list non-empty, alloc_pr is meaningful
//   free_enable    retire returns a displaced physical register
//   free_pr        physical register being returned (PR 0 is never freed)
//   retire_enable  retiring instruction had allocated; advances retired head
//   restore_enable mispredict recovery; head rolls back to retired head
//   free_count     registered number of entries available to allocate
//   error          sticky protocol-violation flag (overflow / retire overrun)
module free_list #(
  parameter int unsigned PHYS_REG_SZ = 64,
  parameter int unsigned ARCH_REG_SZ = 32,
  localparam int unsigned DEPTH = PHYS_REG_SZ - ARCH_REG_SZ,
  localparam int unsigned PW    = $clog2(PHYS_REG_SZ),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alloc_req,
  output logic [PW-1:0] alloc_pr,
  output logic          alloc_valid,
  input  logic          free_enable,
  input  logic [PW-1:0] free_pr,
  input  logic          retire_enable,
  input  logic          restore_enable,
  output logic [CW-1:0] free_count,
  output logic          error
);

  // Index width; pointers carry one extra wrap bit on top.
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0] mem [DEPTH];
  logic [IW:0]   head;
  logic [IW:0]   retired_head;
  logic [IW:0]   tail;

  logic [IW:0]   head_n;
  logic [IW:0]   retired_head_n;
  logic [IW:0]   tail_n;
  logic [CW-1:0] count_n;
  logic          full;
  logic          grant;
  logic          free_ok;
  logic          free_ovf;
  logic          retire_ok;
  logic          retire_bad;

  // Advance a pointer, wrapping DEPTH-1 -> 0 and toggling the wrap bit.
  function automatic logic [IW:0] ptr_inc(input logic [IW:0] p);
    if (p[IW-1:0] == IW'(DEPTH - 1)) begin
      return {~p[IW], IW'(0)};
    end
    return {p[IW], p[IW-1:0] + IW'(1)};
  endfunction

  // Occupancy tail - head modulo 2*DEPTH, using the wrap bits.
  function automatic logic [CW-1:0] ptr_diff(input logic [IW:0] t, input logic [IW:0] h);
    if (t[IW] == h[IW]) begin
      return CW'(t[IW-1:0]) - CW'(h[IW-1:0]);
    end
    return CW'(DEPTH) - CW'(h[IW-1:0]) + CW'(t[IW-1:0]);
  endfunction

  assign alloc_pr    = mem[head[IW-1:0]];
  assign alloc_valid = (free_count != '0);

  // Next-state pointer and flag logic.
  always_comb begin
    full           = (free_count == CW'(DEPTH));
    grant          = alloc_req && alloc_valid && !restore_enable;
    // Fullness is judged before any same-cycle grant; a grant never makes room.
    free_ok        = free_enable && (free_pr != '0) && !full;
    free_ovf       = free_enable && (free_pr != '0) && full;
    retire_ok      = retire_enable && (retired_head != head);
    retire_bad     = retire_enable && (retired_head == head);

    retired_head_n = retired_head;
    head_n         = head;
    tail_n         = tail;

    if (retire_ok) begin
      retired_head_n = ptr_inc(retired_head);
    end
    // Restore lands on the retired head including any same-cycle retire.
    if (restore_enable) begin
      head_n = retired_head_n;
    end else if (grant) begin
      head_n = ptr_inc(head);
    end
    if (free_ok) begin
      tail_n = ptr_inc(tail);
    end
    count_n = ptr_diff(tail_n, head_n);
  end

  // State registers; reset preloads the list with the non-architectural PRs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= PW'(ARCH_REG_SZ + 32'(i));
      end
      head         <= '0;
      retired_head <= '0;
      tail         <= {1'b1, IW'(0)};
      free_count   <= CW'(DEPTH);
      error        <= 1'b0;
    end else begin
      if (free_ok) begin
        mem[tail[IW-1:0]] <= free_pr;
      end
      head         <= head_n;
      retired_head <= retired_head_n;
      tail         <= tail_n;
      free_count   <= count_n;
      error        <= error | free_ovf | retire_bad;
    end
  end

endmodule
